// File: rtl/seg7_scan_driver.sv
// Purpose  : time-multiplexed N-digit seven-segment driver with per-frame input snapshot and anti-ghost blanking.
// Latency  : outputs are registered, one clock behind the index/snapshot/blank state.
// Backpress: none; Clk1KHzEn strobes are always honoured, including during blanking.
module seg7_scan_driver #(
   parameter int                    NUM_DIGITS  = 8,
   parameter int                    DWELL_TICKS = 1,
   parameter int                    BLANK_CLKS  = 16,
   parameter logic [NUM_DIGITS-1:0] DIGIT_MASK  = '1
) (
   input  logic                      Clk100MHz,
   input  logic                      reset_n,
   input  logic                      Clk1KHzEn,
   input  logic [4*NUM_DIGITS-1:0]   Data,
   input  logic [NUM_DIGITS-1:0]     XDP,
   output logic [NUM_DIGITS-1:0]     An,
   output logic [6:0]                Seg,
   output logic                      Dp
);

   localparam int IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)   : 1;
   localparam int DWL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS)  : 1;
   localparam int BLK_W = (BLANK_CLKS > 0)  ? $clog2(BLANK_CLKS+1) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DWL_W-1:0] LAST_DWL   = DWL_W'(DWELL_TICKS - 1);
   localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(BLANK_CLKS);

   logic [IDX_W-1:0]        r_idx;
   logic [DWL_W-1:0]        r_dwell;
   logic [BLK_W-1:0]        r_blank;
   logic                    r_load_pend;
   logic [4*NUM_DIGITS-1:0] r_data_snap;
   logic [NUM_DIGITS-1:0]   r_xdp_snap;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic                    w_advance;
   logic                    w_wrap;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic [DWL_W-1:0]        w_dwell_nxt;
   logic [BLK_W-1:0]        w_blank_nxt;
   logic [3:0]              w_nib;
   logic                    w_digit_on;
   logic [6:0]              w_seg_dec;
   logic [NUM_DIGITS-1:0]   w_an_nxt;
   logic [6:0]              w_seg_nxt;
   logic                    w_dp_nxt;

   // Scan sequencing: dwell counting, digit advance with explicit wrap, blank reload/decrement.
   always_comb begin
      w_advance   = Clk1KHzEn && (r_dwell == LAST_DWL);
      w_wrap      = w_advance && (r_idx == LAST_IDX);
      w_idx_nxt   = r_idx;
      w_dwell_nxt = r_dwell;
      w_blank_nxt = r_blank;
      if (w_advance) begin
         w_dwell_nxt = '0;
         w_idx_nxt   = w_wrap ? '0 : r_idx + IDX_W'(1);
         w_blank_nxt = BLANK_LOAD;
      end else begin
         if (Clk1KHzEn) begin
            w_dwell_nxt = r_dwell + DWL_W'(1);
         end
         if (r_blank != '0) begin
            w_blank_nxt = r_blank - BLK_W'(1);
         end
      end
   end

   // Output path reads only the snapshot, never the live inputs.
   always_comb begin
      w_nib      = r_data_snap[{r_idx, 2'b00} +: 4];
      w_digit_on = DIGIT_MASK[r_idx];
      case (w_nib)
         4'h0:    w_seg_dec = 7'h40;
         4'h1:    w_seg_dec = 7'h79;
         4'h2:    w_seg_dec = 7'h24;
         4'h3:    w_seg_dec = 7'h30;
         4'h4:    w_seg_dec = 7'h19;
         4'h5:    w_seg_dec = 7'h12;
         4'h6:    w_seg_dec = 7'h02;
         4'h7:    w_seg_dec = 7'h78;
         4'h8:    w_seg_dec = 7'h00;
         4'h9:    w_seg_dec = 7'h10;
         4'hA:    w_seg_dec = 7'h08;
         4'hB:    w_seg_dec = 7'h03;
         4'hC:    w_seg_dec = 7'h46;
         4'hD:    w_seg_dec = 7'h21;
         4'hE:    w_seg_dec = 7'h06;
         default: w_seg_dec = 7'h0E;
      endcase
      w_an_nxt  = '1;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      if (w_digit_on) begin
         w_seg_nxt = w_seg_dec;
         w_dp_nxt  = r_xdp_snap[r_idx];
         // Anode stays dark while blanking so the previous segment pattern never ghosts onto the new digit.
         if (r_blank == '0) begin
            w_an_nxt[r_idx] = 1'b0;
         end
      end
   end

   // State and output registers; snapshot refreshes after reset release and at every wrap to digit 0.
   always_ff @(posedge Clk100MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_idx       <= '0;
         r_dwell     <= '0;
         r_blank     <= '0;
         r_load_pend <= 1'b1;
         r_data_snap <= '0;
         r_xdp_snap  <= '0;
         r_an        <= '1;
         r_seg       <= 7'h7F;
         r_dp        <= 1'b1;
      end else begin
         r_idx       <= w_idx_nxt;
         r_dwell     <= w_dwell_nxt;
         r_blank     <= w_blank_nxt;
         r_load_pend <= 1'b0;
         if (r_load_pend || w_wrap) begin
            r_data_snap <= Data;
            r_xdp_snap  <= XDP;
         end
         r_an        <= w_an_nxt;
         r_seg       <= w_seg_nxt;
         r_dp        <= w_dp_nxt;
      end
   end

   assign An  = r_an;
   assign Seg = r_seg;
   assign Dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        strobe;
   logic [31:0] data;
   logic [7:0]  xdp;

   logic [7:0]  a_an, m_an, d_an;
   logic [6:0]  a_seg, m_seg, d_seg;
   logic        a_dp, m_dp, d_dp;

   int n_checks = 0;
   int n_fail   = 0;

   // Default configuration
   seg7_scan_driver u_a (
      .Clk100MHz(clk), .reset_n(rst_n), .Clk1KHzEn(strobe), .Data(data), .XDP(xdp),
      .An(a_an), .Seg(a_seg), .Dp(a_dp)
   );

   // Digit 0 masked dark
   seg7_scan_driver #(.DIGIT_MASK(8'hFE)) u_m (
      .Clk100MHz(clk), .reset_n(rst_n), .Clk1KHzEn(strobe), .Data(data), .XDP(xdp),
      .An(m_an), .Seg(m_seg), .Dp(m_dp)
   );

   // Three strobes per digit
   seg7_scan_driver #(.DWELL_TICKS(3)) u_d (
      .Clk100MHz(clk), .reset_n(rst_n), .Clk1KHzEn(strobe), .Data(data), .XDP(xdp),
      .An(d_an), .Seg(d_seg), .Dp(d_dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  a_an;
      logic [6:0]  a_seg;
      logic        a_dp;
      logic [7:0]  m_an;
      logic [6:0]  m_seg;
      logic        m_dp;
      logic [7:0]  d_an;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Strobe for one clock; returns at the negedge after the strobe edge.
   task automatic pulse();
      @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
   endtask

   function automatic vec_t mk(input logic [31:0] dt, input logic [7:0] an, input logic [6:0] sg,
                               input logic dp, input logic [7:0] dan);
      vec_t v;
      v.data  = dt;
      v.a_an  = an;
      v.a_seg = sg;
      v.a_dp  = dp;
      v.m_an  = (an == 8'hFE) ? 8'hFF : an;
      v.m_seg = (an == 8'hFE) ? 7'h7F : sg;
      v.m_dp  = (an == 8'hFE) ? 1'b1  : dp;
      v.d_an  = dan;
      return v;
   endfunction

   initial begin
      int nff;
      int bad;

      // Strobe s = 1..16; Data is applied in the same cycle as the strobe.
      vecs[0]  = mk(32'h0000_0A53, 8'hFD, 7'h12, 1'b0, 8'hFE);
      vecs[1]  = mk(32'h0000_0A53, 8'hFB, 7'h08, 1'b0, 8'hFE);
      vecs[2]  = mk(32'h0000_0008, 8'hF7, 7'h40, 1'b1, 8'hFD);
      vecs[3]  = mk(32'h0000_0008, 8'hEF, 7'h40, 1'b1, 8'hFD);
      vecs[4]  = mk(32'hFFFF_FFF8, 8'hDF, 7'h40, 1'b1, 8'hFD);
      vecs[5]  = mk(32'hFFFF_FFF8, 8'hBF, 7'h40, 1'b1, 8'hFB);
      vecs[6]  = mk(32'hFFFF_FFF8, 8'h7F, 7'h40, 1'b1, 8'hFB);
      vecs[7]  = mk(32'hFFFF_FFF8, 8'hFE, 7'h00, 1'b1, 8'hFB);
      vecs[8]  = mk(32'hFFFF_FFF8, 8'hFD, 7'h0E, 1'b0, 8'hF7);
      vecs[9]  = mk(32'hFFFF_FFF8, 8'hFB, 7'h0E, 1'b0, 8'hF7);
      vecs[10] = mk(32'hFFFF_FFF8, 8'hF7, 7'h0E, 1'b1, 8'hF7);
      vecs[11] = mk(32'hFFFF_FFF8, 8'hEF, 7'h0E, 1'b1, 8'hEF);
      vecs[12] = mk(32'hFFFF_FFF8, 8'hDF, 7'h0E, 1'b1, 8'hEF);
      vecs[13] = mk(32'hFFFF_FFF8, 8'hBF, 7'h0E, 1'b1, 8'hEF);
      vecs[14] = mk(32'hFFFF_FFF8, 8'h7F, 7'h0E, 1'b1, 8'hDF);
      vecs[15] = mk(32'h0000_0007, 8'hFE, 7'h78, 1'b1, 8'hDF);

      rst_n  = 1'b0;
      strobe = 1'b0;
      data   = 32'h0000_0A53;
      xdp    = 8'hF9;
      idle(5);
      chk("reset_an",  {24'd0, a_an},  32'hFF);
      chk("reset_seg", {25'd0, a_seg}, 32'h7F);
      chk("reset_dp",  {31'd0, a_dp},  32'h1);

      rst_n = 1'b1;
      idle(3);
      chk("d0_an",  {24'd0, a_an},  32'hFE);
      chk("d0_seg", {25'd0, a_seg}, 32'h30);
      chk("d0_dp",  {31'd0, a_dp},  32'h1);
      chk("d0_dwell3_an", {24'd0, d_an}, 32'hFE);

      // Masked digit 0 must stay dark across its whole dwell.
      bad = 0;
      for (int k = 0; k < 9; k++) begin
         idle(100);
         if (m_an !== 8'hFF || m_seg !== 7'h7F || m_dp !== 1'b1) bad++;
      end
      chk("mask_d0_dark_samples_bad", bad, 0);
      idle(90);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         data   = vecs[i].data;
         strobe = 1'b1;
         @(negedge clk);
         strobe = 1'b0;
         nff = 0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_an === 8'hFF) nff++;
            if (k == 16) chk($sformatf("s%0d_blank_last", i+1), {24'd0, a_an}, 32'hFF);
         end
         chk($sformatf("s%0d_blank_clks", i+1), nff, 16);
         chk($sformatf("s%0d_an", i+1),    {24'd0, a_an},  {24'd0, vecs[i].a_an});
         chk($sformatf("s%0d_seg", i+1),   {25'd0, a_seg}, {25'd0, vecs[i].a_seg});
         chk($sformatf("s%0d_dp", i+1),    {31'd0, a_dp},  {31'd0, vecs[i].a_dp});
         chk($sformatf("s%0d_m_an", i+1),  {24'd0, m_an},  {24'd0, vecs[i].m_an});
         chk($sformatf("s%0d_m_seg", i+1), {25'd0, m_seg}, {25'd0, vecs[i].m_seg});
         chk($sformatf("s%0d_m_dp", i+1),  {31'd0, m_dp},  {31'd0, vecs[i].m_dp});
         chk($sformatf("s%0d_d_an", i+1),  {24'd0, d_an},  {24'd0, vecs[i].d_an});
         idle(977);
      end

      // Advance to digit 5, then pulse reset between clock edges.
      for (int s = 0; s < 5; s++) begin
         pulse();
         idle(998);
      end
      chk("pre_rst_an",  {24'd0, a_an},  32'hDF);
      chk("pre_rst_seg", {25'd0, a_seg}, 32'h40);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      data  = 32'h0000_0009;
      #1;
      chk("async_rst_an",   {24'd0, a_an},  32'hFF);
      chk("async_rst_seg",  {25'd0, a_seg}, 32'h7F);
      chk("async_rst_dp",   {31'd0, a_dp},  32'h1);
      chk("async_rst_d_an", {24'd0, d_an},  32'hFF);
      idle(2);
      rst_n = 1'b1;
      idle(3);
      chk("post_rst_an",    {24'd0, a_an},  32'hFE);
      chk("post_rst_seg",   {25'd0, a_seg}, 32'h10);
      chk("post_rst_dp",    {31'd0, a_dp},  32'h1);
      chk("post_rst_d_an",  {24'd0, d_an},  32'hFE);
      chk("post_rst_m_an",  {24'd0, m_an},  32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
